// File: rtl/mem_ctrl_pkg.sv
`default_nettype none
// -----------------------------------------------------------------------------
// Module   : mem_ctrl_pkg
// Brief    : Bus widths, FSM state encoding and transfer-length codes for mem_ctrl.
// Revision : 1.0
// -----------------------------------------------------------------------------
package mem_ctrl_pkg;

  localparam int MEM_ADDR_BUS = 32;
  localparam int INST_BUS     = 32;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_IF_RD  = 2'd1,
    ST_MEM_RD = 2'd2,
    ST_MEM_WR = 2'd3
  } state_e;

  localparam logic [1:0] LEN_BYTE     = 2'b00;
  localparam logic [1:0] LEN_HALF     = 2'b01;
  localparam logic [1:0] LEN_WORD     = 2'b10;
  localparam logic [1:0] LEN_WORD_ALT = 2'b11;

  function automatic logic [2:0] len_to_bytes(input logic [1:0] len);
    case (len)
      LEN_BYTE:               return 3'd1;
      LEN_HALF:               return 3'd2;
      LEN_WORD, LEN_WORD_ALT: return 3'd4;
      default:                return 3'd4;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/mem_ctrl.sv
`default_nettype none
// -----------------------------------------------------------------------------
// Module   : mem_ctrl
// Brief    : Byte-serial RAM controller arbitrating IF fetches and MEM loads/stores.
// Revision : 1.0
// -----------------------------------------------------------------------------
module mem_ctrl
  import mem_ctrl_pkg::*;
(
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    if_read,
  input  logic [MEM_ADDR_BUS-1:0] if_addr,
  output logic                    if_ready,
  output logic [INST_BUS-1:0]     if_data,
  input  logic                    mem_read,
  input  logic                    mem_write,
  input  logic [MEM_ADDR_BUS-1:0] mem_addr,
  input  logic [1:0]              mem_len,
  input  logic [31:0]             mem_wdata,
  output logic                    mem_ready,
  output logic [31:0]             mem_rdata,
  output logic                    ram_rw,
  output logic [MEM_ADDR_BUS-1:0] ram_a,
  output logic [7:0]              ram_dout,
  input  logic [7:0]              ram_din
);

  state_e                  state_q;
  logic [MEM_ADDR_BUS-1:0] addr_q;
  logic [2:0]              nbytes_q;
  logic [31:0]             wdata_q;
  logic [2:0]              cyc_q;
  logic [31:0]             rbuf_q;
  logic                    if_ready_q;
  logic                    mem_ready_q;
  logic [INST_BUS-1:0]     if_data_q;
  logic [31:0]             mem_rdata_q;
  logic                    ram_rw_q;
  logic [MEM_ADDR_BUS-1:0] ram_a_q;
  logic [7:0]              ram_dout_q;

  logic                    mem_req_d;
  logic                    if_req_d;
  logic [2:0]              cyc_next_d;
  logic [1:0]              lane_d;
  logic [31:0]             rbuf_d;
  logic [MEM_ADDR_BUS-1:0] next_addr_d;

  // A port whose ready is high this cycle is still holding its old request.
  assign mem_req_d   = (mem_read | mem_write) & ~mem_ready_q;
  assign if_req_d    = if_read & ~if_ready_q;

  // cyc_q counts cycles since acceptance; RAM returns byte k-1 while cyc_q = k.
  assign cyc_next_d  = cyc_q + 3'd1;
  assign lane_d      = cyc_q[1:0] - 2'd1;
  assign rbuf_d      = rbuf_q | ({24'd0, ram_din} << {lane_d, 3'b000});
  assign next_addr_d = addr_q + {{(MEM_ADDR_BUS-3){1'b0}}, cyc_next_d};

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      addr_q      <= '0;
      nbytes_q    <= '0;
      wdata_q     <= '0;
      cyc_q       <= '0;
      rbuf_q      <= '0;
      if_ready_q  <= 1'b0;
      mem_ready_q <= 1'b0;
      if_data_q   <= '0;
      mem_rdata_q <= '0;
      ram_rw_q    <= 1'b0;
      ram_a_q     <= '0;
      ram_dout_q  <= '0;
    end else begin
      if_ready_q  <= 1'b0;
      mem_ready_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          cyc_q  <= '0;
          rbuf_q <= '0;
          if (mem_req_d) begin
            state_q    <= mem_write ? ST_MEM_WR : ST_MEM_RD;
            addr_q     <= mem_addr;
            nbytes_q   <= len_to_bytes(mem_len);
            wdata_q    <= mem_wdata;
            ram_a_q    <= mem_addr;
            ram_rw_q   <= mem_write;
            ram_dout_q <= mem_write ? mem_wdata[7:0] : 8'h00;
          end else if (if_req_d) begin
            state_q    <= ST_IF_RD;
            addr_q     <= if_addr;
            nbytes_q   <= 3'd4;
            wdata_q    <= '0;
            ram_a_q    <= if_addr;
            ram_rw_q   <= 1'b0;
            ram_dout_q <= '0;
          end else begin
            ram_a_q    <= '0;
            ram_rw_q   <= 1'b0;
            ram_dout_q <= '0;
          end
        end

        ST_IF_RD, ST_MEM_RD: begin
          // A withdrawn fetch is a pipeline flush; loads always run to completion.
          if ((state_q == ST_IF_RD) && !if_read) begin
            state_q <= ST_IDLE;
            ram_a_q <= '0;
          end else begin
            cyc_q   <= cyc_next_d;
            ram_a_q <= (cyc_next_d < nbytes_q) ? next_addr_d : '0;
            if (cyc_q != 3'd0) begin
              rbuf_q <= rbuf_d;
            end
            if (cyc_q == nbytes_q) begin
              state_q <= ST_IDLE;
              if (state_q == ST_IF_RD) begin
                if_ready_q <= 1'b1;
                if_data_q  <= rbuf_d;
              end else begin
                mem_ready_q <= 1'b1;
                mem_rdata_q <= rbuf_d;
              end
            end
          end
        end

        ST_MEM_WR: begin
          cyc_q <= cyc_next_d;
          if (cyc_next_d < nbytes_q) begin
            ram_a_q    <= next_addr_d;
            ram_rw_q   <= 1'b1;
            ram_dout_q <= wdata_q[{cyc_next_d[1:0], 3'b000} +: 8];
          end else begin
            state_q     <= ST_IDLE;
            ram_a_q     <= '0;
            ram_rw_q    <= 1'b0;
            ram_dout_q  <= '0;
            mem_ready_q <= 1'b1;
          end
        end

        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign if_ready  = if_ready_q;
  assign if_data   = if_data_q;
  assign mem_ready = mem_ready_q;
  assign mem_rdata = mem_rdata_q;
  assign ram_rw    = ram_rw_q;
  assign ram_a     = ram_a_q;
  assign ram_dout  = ram_dout_q;

endmodule
`default_nettype wire
